sprite_dma_ctl: RTL and testbench

SPRITE_DMA_CTL -- requirements
Module: sprite_dma_ctl

---
 rtl/sprite_dma_ctl_if.sv | 27 ++
 rtl/sprite_dma_ctl.sv | 85 ++++++++
 tb/tb_sprite_dma_ctl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sprite_dma_ctl_if.sv
// sprite_dma_ctl_if: bus bundle between the sprite DMA controller and its environment.
// Ports: I_TRIG/I_ABORT start and stop requests, I_BUSAK arbiter grant,
// I_SRC_BASE/I_DST_BASE/I_LEN/I_MODE/I_FILL transfer setup, I_DMA_DS source read data,
// O_DMA_AS/O_DMA_CES source side, O_DMA_AD/O_DMA_DD/O_DMA_CED/O_DMA_WE destination side,
// O_BUSRQ arbiter request, O_BUSY/O_DONE status.
// master = controller side, slave = environment side.
interface sprite_dma_ctl_if #(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int LW = 11
);
    logic          I_TRIG, I_ABORT, I_BUSAK, I_MODE;
    logic [AW-1:0] I_SRC_BASE, I_DST_BASE;
    logic [LW-1:0] I_LEN;
    logic [DW-1:0] I_FILL, I_DMA_DS;
    logic [AW-1:0] O_DMA_AS, O_DMA_AD;
    logic [DW-1:0] O_DMA_DD;
    logic          O_DMA_CES, O_DMA_CED, O_DMA_WE, O_BUSRQ, O_BUSY, O_DONE;
    modport master (
        input  I_TRIG, I_ABORT, I_BUSAK, I_MODE, I_SRC_BASE, I_DST_BASE, I_LEN, I_FILL, I_DMA_DS,
        output O_DMA_AS, O_DMA_AD, O_DMA_DD, O_DMA_CES, O_DMA_CED, O_DMA_WE, O_BUSRQ, O_BUSY, O_DONE
    );
    modport slave (
        output I_TRIG, I_ABORT, I_BUSAK, I_MODE, I_SRC_BASE, I_DST_BASE, I_LEN, I_FILL, I_DMA_DS,
        input  O_DMA_AS, O_DMA_AD, O_DMA_DD, O_DMA_CES, O_DMA_CED, O_DMA_WE, O_BUSRQ, O_BUSY, O_DONE
    );
endinterface

// File: rtl/sprite_dma_ctl.sv
// sprite_dma_ctl: byte-wise copy/fill DMA engine with bus request/grant handshake.
// Ports: I_CLK clock, I_RSTn synchronous active-low reset, bus (sprite_dma_ctl_if.master)
// carrying trigger/abort/grant, transfer setup, source read and destination write signals.
// Each byte walks RD -> LAT -> WR -> NXT; losing the grant freezes the current state.
module sprite_dma_ctl #(
    parameter int AW = 10,
    parameter int DW = 8,
    parameter int LW = 11
) (
    input logic              I_CLK,
    input logic              I_RSTn,
    sprite_dma_ctl_if.master bus
);
    localparam logic [2:0] IDLE = 3'd0, REQ = 3'd1, RD = 3'd2, LAT = 3'd3, WR = 3'd4, NXT = 3'd5;
    logic [2:0]    state;
    logic          trig_q, mode, done, xfer, go;
    logic [AW-1:0] src, dst;
    logic [LW-1:0] len, idx;
    logic [DW-1:0] fill, dd;
    // Strobes are gated by the live grant so a dropped grant silences them in the same cycle.
    always_comb begin
        xfer = (state inside {RD, LAT, WR, NXT}) && bus.I_BUSAK;
        go   = bus.I_TRIG && !trig_q && !bus.I_ABORT;
    end
    assign bus.O_DMA_AS  = src + AW'(idx);
    assign bus.O_DMA_AD  = dst + AW'(idx);
    assign bus.O_DMA_DD  = dd;
    assign bus.O_DMA_CES = xfer;
    assign bus.O_DMA_CED = xfer;
    assign bus.O_DMA_WE  = state == WR && bus.I_BUSAK;
    assign bus.O_BUSRQ   = state != IDLE;
    assign bus.O_BUSY    = state != IDLE;
    assign bus.O_DONE    = done;
    always_ff @(posedge I_CLK) begin
        if (!I_RSTn) begin
            state  <= IDLE;
            trig_q <= 1'b0;
            done   <= 1'b0;
            mode   <= 1'b0;
            src    <= '0;
            dst    <= '0;
            len    <= '0;
            idx    <= '0;
            fill   <= '0;
            dd     <= '0;
        end else begin
            trig_q <= bus.I_TRIG;
            done   <= 1'b0;
            if (bus.I_ABORT && state != IDLE)
                state <= IDLE;
            else
                case (state)
                    IDLE: if (go) begin
                        src  <= bus.I_SRC_BASE;
                        dst  <= bus.I_DST_BASE;
                        len  <= bus.I_LEN;
                        mode <= bus.I_MODE;
                        fill <= bus.I_FILL;
                        idx  <= '0;
                        if (bus.I_LEN == '0)
                            done <= 1'b1;
                        else
                            state <= REQ;
                    end
                    REQ: if (bus.I_BUSAK) state <= RD;
                    RD:  if (bus.I_BUSAK) state <= LAT;
                    LAT: if (bus.I_BUSAK) begin
                        dd    <= mode ? fill : bus.I_DMA_DS;
                        state <= WR;
                    end
                    WR:  if (bus.I_BUSAK) state <= NXT;
                    NXT: if (bus.I_BUSAK) begin
                        if (idx == len - 1'b1) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            idx   <= idx + 1'b1;
                            state <= RD;
                        end
                    end
                    default: state <= IDLE;
                endcase
        end
    end
endmodule

// File: tb/tb_sprite_dma_ctl.sv
// tb_sprite_dma_ctl: table-driven, directed and randomized checks of sprite_dma_ctl.
module tb_sprite_dma_ctl;
    typedef struct {
        logic [9:0]  src, dst;
        logic [10:0] len;
        logic        mode;
        logic [7:0]  fill;
        int          lat;
        logic [9:0]  last_ad;
        logic [7:0]  last_dd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] ds = '0;
    logic [7:0] mem [1024];
    logic [9:0] wr_ad [$];
    logic [7:0] wr_dd [$];
    int         done_cnt = 0, rq_cnt = 0;
    int         checks = 0, errors = 0;
    int         wb, dc, lat, rq0;
    vec_t       v [6];

    sprite_dma_ctl_if #(.AW(10), .DW(8), .LW(11)) bus ();
    sprite_dma_ctl #(.AW(10), .DW(8), .LW(11)) dut (.I_CLK(clk), .I_RSTn(rst_n), .bus(bus.master));

    always #5 clk = ~clk;

    // Source memory: synchronous read, data valid the cycle after an enabled address.
    always @(posedge clk) if (bus.O_DMA_CES) ds <= mem[bus.O_DMA_AS];
    assign bus.I_DMA_DS = ds;

    // Passive monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.O_DMA_WE) begin
            wr_ad.push_back(bus.O_DMA_AD);
            wr_dd.push_back(bus.O_DMA_DD);
        end
        if (bus.O_DONE) done_cnt++;
        if (bus.O_BUSRQ) rq_cnt++;
    end

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual %0h required %0h", name, act, exp);
        end
    endtask

    // Triggers one transfer, waits for DONE and compares every write with the expected
    // byte list: dst+k receives fill or mem[src+k], modulo 1024.
    task automatic run_xfer(input logic [9:0] src, input logic [9:0] dst, input logic [10:0] len,
                            input logic mode, input logic [7:0] fill, input bit rnd, input bit retrig,
                            output int l);
        int b, d, n;
        bus.I_SRC_BASE = src;
        bus.I_DST_BASE = dst;
        bus.I_LEN      = len;
        bus.I_MODE     = mode;
        bus.I_FILL     = fill;
        bus.I_TRIG     = 1'b1;
        b = wr_ad.size();
        d = done_cnt;
        l = 0;
        do begin
            clk1();
            l++;
            bus.I_TRIG     = retrig && (l % 5 == 3);
            bus.I_SRC_BASE = 10'($urandom);
            bus.I_DST_BASE = 10'($urandom);
            bus.I_LEN      = 11'($urandom);
            bus.I_MODE     = 1'($urandom);
            bus.I_FILL     = 8'($urandom);
            if (rnd) bus.I_BUSAK = ($urandom_range(0, 3) != 0);
            @(negedge clk);
        end while (!bus.O_DONE && l < 9000);
        chk("done_seen", bus.O_DONE, 1);
        bus.I_TRIG  = 1'b0;
        bus.I_BUSAK = 1'b1;
        clk1();
        chk("done_pulses", done_cnt - d, 1);
        n = wr_ad.size() - b;
        chk("we_count", n, len);
        for (int k = 0; k < n && k < int'(len); k++) begin
            chk("wr_addr", wr_ad[b+k], 10'(dst + k));
            chk("wr_data", wr_dd[b+k], mode ? fill : mem[10'(src + k)]);
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.I_TRIG     = 1'b0;
        bus.I_ABORT    = 1'b0;
        bus.I_BUSAK    = 1'b1;
        bus.I_SRC_BASE = '0;
        bus.I_DST_BASE = '0;
        bus.I_LEN      = '0;
        bus.I_MODE     = 1'b0;
        bus.I_FILL     = '0;
        for (int a = 0; a < 1024; a++) mem[a] = 8'(a) ^ 8'h5A;
        v[0] = '{10'h100, 10'h000, 11'h19F, 1'b0, 8'h00, 1662, 10'h19E, 8'hC4};
        v[1] = '{10'h000, 10'h3FE, 11'd4,   1'b1, 8'hA5, 18,   10'h001, 8'hA5};
        v[2] = '{10'h155, 10'h2AA, 11'd0,   1'b0, 8'h00, 1,    10'h000, 8'h00};
        v[3] = '{10'h3FF, 10'h200, 11'd1,   1'b0, 8'h00, 6,    10'h200, 8'hA5};
        v[4] = '{10'h3FC, 10'h010, 11'd6,   1'b0, 8'h00, 26,   10'h015, 8'h5B};
        v[5] = '{10'h3FF, 10'h3FF, 11'd2047, 1'b1, 8'h3C, 8190, 10'h3FD, 8'h3C};

        repeat (3) clk1();
        @(negedge clk);
        chk("rst_as",    bus.O_DMA_AS, 0);
        chk("rst_ad",    bus.O_DMA_AD, 0);
        chk("rst_dd",    bus.O_DMA_DD, 0);
        chk("rst_ces",   bus.O_DMA_CES, 0);
        chk("rst_ced",   bus.O_DMA_CED, 0);
        chk("rst_we",    bus.O_DMA_WE, 0);
        chk("rst_busrq", bus.O_BUSRQ, 0);
        chk("rst_busy",  bus.O_BUSY, 0);
        chk("rst_done",  bus.O_DONE, 0);
        clk1();
        rst_n = 1'b1;
        clk1();

        for (int t = 0; t < 6; t++) begin
            rq0 = rq_cnt;
            run_xfer(v[t].src, v[t].dst, v[t].len, v[t].mode, v[t].fill, 1'b0, 1'b0, lat);
            chk("latency", lat, v[t].lat);
            chk("busrq_cycles", rq_cnt - rq0, v[t].lat - 1);
            if (v[t].len != 0) begin
                chk("last_ad", wr_ad[$], v[t].last_ad);
                chk("last_dd", wr_dd[$], v[t].last_dd);
            end
        end

        // Abort coincident with a start edge: start ignored, no later start from a held level.
        bus.I_TRIG  = 1'b1;
        bus.I_ABORT = 1'b1;
        clk1();
        bus.I_ABORT = 1'b0;
        @(negedge clk);
        chk("abort_start_ignored", bus.O_BUSY, 0);
        clk1();
        @(negedge clk);
        chk("held_trig_no_start", bus.O_BUSY, 0);
        bus.I_TRIG = 1'b0;
        clk1();

        // Grant handshake: 10 cycles without grant, then a 3-cycle drop in WR of byte 2.
        bus.I_SRC_BASE = 10'h040;
        bus.I_DST_BASE = 10'h020;
        bus.I_LEN      = 11'd4;
        bus.I_MODE     = 1'b0;
        bus.I_TRIG     = 1'b1;
        bus.I_BUSAK    = 1'b0;
        wb = wr_ad.size();
        dc = done_cnt;
        for (int c = 1; c <= 10; c++) begin
            clk1();
            bus.I_TRIG = 1'b0;
            @(negedge clk);
            chk("grant_wait_rq", bus.O_BUSRQ, 1);
            chk("grant_wait_ces", bus.O_DMA_CES, 0);
        end
        clk1();
        bus.I_BUSAK = 1'b1;
        @(negedge clk);
        chk("grant_still_req", bus.O_DMA_CES, 0);
        clk1();
        @(negedge clk);
        chk("grant_rd_ces", bus.O_DMA_CES, 1);
        chk("grant_rd_as", bus.O_DMA_AS, 10'h040);
        for (int c = 13; c <= 21; c++) clk1();
        for (int c = 22; c <= 24; c++) begin
            clk1();
            bus.I_BUSAK = 1'b0;
            @(negedge clk);
            chk("freeze_we", bus.O_DMA_WE, 0);
            chk("freeze_ces", bus.O_DMA_CES, 0);
            chk("freeze_ad", bus.O_DMA_AD, 10'h022);
        end
        clk1();
        bus.I_BUSAK = 1'b1;
        @(negedge clk);
        chk("resume_we", bus.O_DMA_WE, 1);
        chk("resume_ad", bus.O_DMA_AD, 10'h022);
        chk("resume_dd", bus.O_DMA_DD, mem[10'h042]);
        for (int c = 0; c < 40 && !bus.O_DONE; c++) begin
            clk1();
            @(negedge clk);
        end
        chk("grant_done_seen", bus.O_DONE, 1);
        clk1();
        chk("grant_done_pulses", done_cnt - dc, 1);
        chk("grant_we_count", wr_ad.size() - wb, 4);
        for (int k = 0; k < 4 && wb + k < wr_ad.size(); k++) begin
            chk("grant_wr_addr", wr_ad[wb+k], 10'(10'h020 + k));
            chk("grant_wr_data", wr_dd[wb+k], mem[10'(10'h040 + k)]);
        end

        // Abort in WR of byte 5: that write completes, nothing follows, no DONE.
        bus.I_SRC_BASE = 10'h080;
        bus.I_DST_BASE = 10'h300;
        bus.I_LEN      = 11'd10;
        bus.I_TRIG     = 1'b1;
        wb = wr_ad.size();
        dc = done_cnt;
        for (int c = 1; c <= 24; c++) begin
            clk1();
            bus.I_TRIG = 1'b0;
        end
        bus.I_ABORT = 1'b1;
        @(negedge clk);
        chk("abort_we_completes", bus.O_DMA_WE, 1);
        chk("abort_we_addr", bus.O_DMA_AD, 10'h305);
        clk1();
        bus.I_ABORT = 1'b0;
        @(negedge clk);
        chk("abort_idle", {bus.O_BUSY, bus.O_BUSRQ, bus.O_DMA_CES, bus.O_DMA_CED, bus.O_DMA_WE}, 0);
        repeat (8) clk1();
        chk("abort_we_count", wr_ad.size() - wb, 6);
        chk("abort_no_done", done_cnt - dc, 0);
        run_xfer(10'h080, 10'h300, 11'd10, 1'b0, 8'h00, 1'b0, 1'b0, lat);
        chk("restart_latency", lat, 42);

        // Retrigger edges while busy are ignored.
        run_xfer(10'h123, 10'h0F0, 11'd12, 1'b0, 8'h00, 1'b0, 1'b1, lat);
        chk("retrig_latency", lat, 50);

        // Randomized transfers with random grant loss against the byte-list model.
        for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom);
        repeat (20)
            run_xfer(10'($urandom), 10'($urandom), 11'($urandom_range(0, 30)), 1'($urandom),
                     8'($urandom), 1'b1, 1'b0, lat);

        // Reset during byte 100 with trigger held high; restart on the first post-reset edge.
        bus.I_SRC_BASE = 10'h000;
        bus.I_DST_BASE = 10'h100;
        bus.I_LEN      = 11'd200;
        bus.I_MODE     = 1'b0;
        bus.I_TRIG     = 1'b1;
        dc = done_cnt;
        for (int c = 1; c <= 403; c++) clk1();
        rst_n = 1'b0;
        clk1();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_mid_outputs", {bus.O_DMA_AS, bus.O_DMA_AD, bus.O_DMA_DD, bus.O_DMA_CES, bus.O_DMA_CED,
                                bus.O_DMA_WE, bus.O_BUSRQ, bus.O_BUSY, bus.O_DONE}, 0);
        chk("rst_mid_no_done", done_cnt - dc, 0);
        run_xfer(10'h3F0, 10'h3FD, 11'd5, 1'b0, 8'h00, 1'b0, 1'b0, lat);
        chk("post_rst_latency", lat, 22);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
